sram_flit_streamer: RTL and testbench

//  Read-side sequencer for the single-port synchronous input SRAM (1-cycle read latency, data+tail per word).

---
 rtl/sram_flit_streamer.sv | 123 ++++++++++++
 tb/tb_sram_flit_streamer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_flit_streamer.sv
// rtl/sram_flit_streamer.sv - SRAM read sequencer turning tail-delimited words into a valid/ready flit stream
module sram_flit_streamer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_FLITS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rtail,
  output logic [DATA_W-1:0] flit_data,
  output logic              flit_tail,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FLITS);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_FLITS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  issued;
  logic              inflight, inflight_last, tail_seen;
  logic [DATA_W:0]   buf_mem [2];
  logic              wr_idx, rd_idx;
  logic [1:0]        buf_count, occ;
  logic              issue, push, pop, push_tail, tail_xfer;

  assign flit_valid = (buf_count != 2'd0);
  assign {flit_tail, flit_data} = buf_mem[rd_idx];
  assign pop       = flit_valid & flit_ready;
  assign tail_xfer = pop & flit_tail;
  // Returns after the tail are overshoot reads and are dropped here.
  assign push      = inflight & ~tail_seen;
  assign push_tail = sram_rtail | inflight_last;

  // Slots freed by this cycle's pop count as free so a full-rate stream keeps one read in flight.
  assign occ   = buf_count + {1'b0, inflight} - {1'b0, pop};
  assign issue = (state == ISSUE) && !tail_seen && (issued < MAX_CNT) && (occ < 2'd2);

  assign sram_cs   = issue;
  assign sram_oe   = issue;
  assign sram_we   = 1'b0;
  assign sram_addr = rd_ptr;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (tail_xfer) state_nxt = DONE;
        else if (tail_seen || issued == MAX_CNT) state_nxt = DRAIN;
      end
      DRAIN: if (tail_xfer) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      tail_seen     <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue && (issued == MAX_M1);
      if (state == IDLE && start) begin
        rd_ptr    <= start_addr;
        issued    <= '0;
        tail_seen <= 1'b0;
        err       <= 1'b0;
      end else begin
        if (issue) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
          issued <= issued + CNT_W'(1);
        end
        if (push && push_tail) tail_seen <= 1'b1;
        if (push && inflight_last && !sram_rtail) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_idx     <= 1'b0;
      rd_idx     <= 1'b0;
      buf_count  <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_idx] <= {push_tail, sram_rdata};
        wr_idx          <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && buf_count == 2'd2));

endmodule

// File: tb/tb_sram_flit_streamer.sv
// tb/tb_sram_flit_streamer.sv - scoreboard bench for sram_flit_streamer
module tb_sram_flit_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [7:0]  sram_addr;
  logic        sram_cs, sram_we, sram_oe;
  logic [15:0] sram_rdata = '0;
  logic        sram_rtail = 1'b0;
  logic [15:0] flit_data;
  logic        flit_tail, flit_valid, busy, done, err;
  logic        flit_ready = 1'b1;

  sram_flit_streamer #(.ADDR_W(8), .DATA_W(16), .MAX_FLITS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_rdata(sram_rdata), .sram_rtail(sram_rtail),
    .flit_data(flit_data), .flit_tail(flit_tail), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_data [256];
  logic        mem_tail [256];

  always @(posedge clk) begin
    if (sram_cs) begin
      sram_rdata <= mem_data[sram_addr];
      sram_rtail <= mem_tail[sram_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];
  int reads, done_cnt, flits_seen, cyc, tail_cyc, done_cyc, first_cyc, last_cyc;
  logic stalled_prev = 1'b0;
  logic [16:0] held;
  logic exp_err;
  int ready_mode = 0;
  logic [3:0] ready_pat = 4'b1001;

  task automatic set_tails(input int t0, input int t1);
    for (int i = 0; i < 256; i++) begin
      mem_data[i] = 16'h0000 | 16'(i);
      mem_tail[i] = (i == t0) || (i == t1);
    end
  endtask

  task automatic tick();
    logic [16:0] exp;
    @(negedge clk);
    if (sram_cs) reads++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (stalled_prev && !rst) begin
      checks++;
      if (!flit_valid || {flit_tail, flit_data} !== held) begin
        errors++;
        $display("FAIL head_stable got v=%b %h required %h", flit_valid, {flit_tail, flit_data}, held);
      end
    end
    stalled_prev = flit_valid && !flit_ready;
    held = {flit_tail, flit_data};
    if (flit_valid && flit_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL flit_extra got %h required none", {flit_tail, flit_data});
      end else begin
        exp = sb.pop_front();
        if ({flit_tail, flit_data} !== exp) begin
          errors++;
          $display("FAIL flit_seq got %h required %h", {flit_tail, flit_data}, exp);
        end
      end
      if (flits_seen == 0) first_cyc = cyc;
      last_cyc = cyc;
      if (flit_tail) tail_cyc = cyc;
      flits_seen++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [7:0] addr);
    logic [7:0] a;
    logic t;
    a = addr;
    exp_err = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      t = mem_tail[a] || (i == 64);
      if (i == 64 && !mem_tail[a]) exp_err = 1'b1;
      sb.push_back({t, mem_data[a]});
      if (t) break;
      a = a + 8'd1;
    end
    reads = 0; flits_seen = 0; tail_cyc = -1; done_cyc = -1;
    start = 1'b1; start_addr = addr;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int d0;
    bit hit;
    d0 = done_cnt;
    hit = 0;
    for (int i = 0; i < budget; i++) begin
      flit_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
      tick();
      if (done_cnt != d0) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s_timeout got no done required done within %0d cycles", name, budget);
    end
    checks++;
    if (done_cyc != tail_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing got done cyc %0d required %0d", name, done_cyc, tail_cyc + 1);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_end got done=%b busy=%b left=%0d required 0 0 0", name, done, busy, sb.size());
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s_err got %b required %b", name, err, exp_err);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({sram_addr, sram_cs, sram_we, sram_oe, flit_data, flit_tail, flit_valid, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL %s got addr=%h cs=%b we=%b oe=%b data=%h tail=%b v=%b busy=%b done=%b err=%b required all 0",
               name, sram_addr, sram_cs, sram_we, sram_oe, flit_data, flit_tail, flit_valid, busy, done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b0;
    tick();
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    set_tails(8'h13, -1);
    ready_mode = 0; flit_ready = 1'b1;
    start_pkt(8'h10);
    checks++;
    if (flit_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_early got v=%b busy=%b required 0 1", flit_valid, busy);
    end
    tick(); tick();
    checks++;
    if (flit_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_first got v=%b required 1", flit_valid);
    end
    run_until_done("basic", 30);
    checks++;
    if (reads != 5 || flits_seen != 4 || last_cyc - first_cyc != 3) begin
      errors++;
      $display("FAIL basic_counts got reads=%0d flits=%0d span=%0d required 5 4 3", reads, flits_seen, last_cyc - first_cyc);
    end
  endtask

  task automatic test_backpressure();
    set_tails(8'h13, -1);
    ready_mode = 1;
    start_pkt(8'h10);
    run_until_done("backpressure", 60);
    checks++;
    if (flits_seen != 4) begin
      errors++;
      $display("FAIL backpressure_count got %0d required 4", flits_seen);
    end
    ready_mode = 0; flit_ready = 1'b1;
  endtask

  task automatic test_wrap();
    set_tails(1, -1);
    start_pkt(8'hFE);
    run_until_done("wrap", 30);
    checks++;
    if (flits_seen != 4) begin
      errors++;
      $display("FAIL wrap_count got %0d required 4", flits_seen);
    end
  endtask

  task automatic test_length_limit();
    set_tails(-1, -1);
    start_pkt(8'h00);
    run_until_done("limit", 300);
    checks++;
    if (flits_seen != 64 || err !== 1'b1) begin
      errors++;
      $display("FAIL limit_count got flits=%0d err=%b required 64 1", flits_seen, err);
    end
  endtask

  task automatic test_single_stalled();
    set_tails(8'h40, -1);
    flit_ready = 1'b0;
    start_pkt(8'h40);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b required 0", err);
    end
    repeat (5) tick();
    checks++;
    if (flit_valid !== 1'b1 || flit_tail !== 1'b1 || flit_data !== 16'h0040 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_hold got v=%b t=%b d=%h done=%b required 1 1 0040 0", flit_valid, flit_tail, flit_data, done);
    end
    ready_mode = 0;
    run_until_done("single", 10);
  endtask

  task automatic test_reset_midpacket();
    int d0;
    bit hit;
    set_tails(8'h07, 8'h22);
    start_pkt(8'h00);
    for (int i = 0; i < 20 && flits_seen < 3; i++) tick();
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset_outputs");
    sb.delete();
    d0 = done_cnt;
    repeat (3) tick();
    check_outputs_zero("midreset_hold");
    rst = 1'b0;
    tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d pulses required 0", done_cnt - d0);
    end
    start_pkt(8'h20);
    hit = 0;
    for (int i = 0; i < 30; i++) begin
      start = busy; start_addr = 8'h50;
      tick();
      if (done_cnt != d0) begin hit = 1; break; end
    end
    start = 1'b0;
    checks++;
    if (!hit || flits_seen != 3 || sb.size() != 0 || done_cyc != tail_cyc + 1) begin
      errors++;
      $display("FAIL restart got done=%0d flits=%0d left=%0d required 1 3 0", hit, flits_seen, sb.size());
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL busy_start_ignored got busy=%b pulses=%0d required 0 1", busy, done_cnt - d0);
    end
  endtask

  initial begin
    reads = 0; done_cnt = 0; flits_seen = 0; cyc = 0;
    tail_cyc = -1; done_cyc = -1; first_cyc = 0; last_cyc = 0;
    exp_err = 1'b0; held = '0;
    set_tails(-1, -1);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_length_limit();
    test_single_stalled();
    test_reset_midpacket();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
